rob_commit_unit: RTL and testbench

- In-order retirement end of the result bus. The data controller writes FU results per reorder-buffer slot; this block allocates those slots at issue and reads them back at commit.
- Tracks head, tail and count of occupied slots. Retires the head slot once its CDB_data_valid bit is set. Drives the register-file write port or the store memory port. Returns the freed slot index so the data controller can clear that slot's valid bit.

---
 rtl/rob_commit_unit_pkg.sv | 29 ++
 rtl/rob_commit_unit_ptr_ctrl.sv | 54 +++++
 rtl/rob_commit_unit.sv | 121 ++++++++++++
 tb/tb_rob_commit_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_commit_unit_pkg.sv
// ============================================================================
// rob_commit_unit_pkg : shared sizes, commit-state encoding, slot-read helper
// Revision 1.0
// ============================================================================
`default_nettype none

package rob_commit_unit_pkg;

    localparam int WORD_SIZE = 32;
    localparam int RB_SIZE   = 8;
    localparam int RB_INDEX  = 3;
    localparam int REG_INDEX = 5;

    localparam logic [RB_INDEX:0] RB_COUNT_FULL = (RB_INDEX + 1)'(RB_SIZE);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_STORE = 1'b1;

    // Pull one WORD_SIZE slot out of a flat per-slot bus.
    function automatic logic [WORD_SIZE-1:0] slot_word(
        input logic [WORD_SIZE*RB_SIZE-1:0] bus,
        input logic [RB_INDEX-1:0]          idx
    );
        return bus[int'(idx)*WORD_SIZE +: WORD_SIZE];
    endfunction

endpackage

`default_nettype wire

// File: rtl/rob_commit_unit_ptr_ctrl.sv
// ============================================================================
// rob_ptr_ctrl : head/tail/occupancy tracking for the reorder buffer
// Revision 1.0
// ============================================================================
`default_nettype none

module rob_ptr_ctrl
    import rob_commit_unit_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                alloc_fire,
    input  logic                retire_fire,
    output logic [RB_INDEX-1:0] head,
    output logic [RB_INDEX-1:0] tail,
    output logic                full,
    output logic                empty
);

    localparam logic [RB_INDEX-1:0] c_ptr_one = RB_INDEX'(1);
    localparam logic [RB_INDEX:0]   c_cnt_one = (RB_INDEX + 1)'(1);

    logic [RB_INDEX:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            r_count <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            r_count <= '0;
        end else begin
            if (alloc_fire)
                tail <= tail + c_ptr_one;
            if (retire_fire)
                head <= head + c_ptr_one;
            // Simultaneous allocate and retire leaves occupancy unchanged.
            case ({alloc_fire, retire_fire})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign full  = (r_count == RB_COUNT_FULL);
    assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/rob_commit_unit.sv
// ============================================================================
// rob_commit_unit : in-order retirement of reorder-buffer slots to the
//                   register file or store port. Revision 1.0
// ============================================================================
`default_nettype none

module rob_commit_unit
    import rob_commit_unit_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data,
    input  logic [RB_SIZE-1:0]            CDB_data_valid,
    input  logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_addr,
    input  logic                          alloc_req,
    input  logic                          alloc_is_store,
    input  logic [REG_INDEX-1:0]          alloc_dest,
    output logic [RB_INDEX-1:0]           alloc_index,
    output logic                          rb_full,
    output logic                          rb_empty,
    output logic                          reg_we,
    output logic [REG_INDEX-1:0]          reg_waddr,
    output logic [WORD_SIZE-1:0]          reg_wdata,
    output logic                          mem_we,
    output logic [WORD_SIZE-1:0]          mem_addr,
    output logic [WORD_SIZE-1:0]          mem_wdata,
    input  logic                          mem_ready,
    output logic                          rb_free_valid,
    output logic [RB_INDEX-1:0]           rb_free_index,
    input  logic                          flush
);

    logic [RB_INDEX-1:0]  head;
    logic [RB_INDEX-1:0]  tail;
    logic                 full;
    logic                 empty;
    logic [0:0]           r_state;
    logic [RB_SIZE-1:0]   r_is_store;
    logic [REG_INDEX-1:0] r_dest [RB_SIZE];

    logic w_eligible;
    logic w_alloc_fire;
    logic w_reg_retire;
    logic w_store_start;
    logic w_store_done;
    logic w_retire_fire;

    // Only the head slot's valid bit matters; flush overrides every event.
    assign w_eligible    = (r_state == S_RUN) && !empty && CDB_data_valid[head];
    assign w_alloc_fire  = alloc_req && !full && !flush;
    assign w_reg_retire  = !flush && w_eligible && !r_is_store[head];
    assign w_store_start = !flush && w_eligible &&  r_is_store[head];
    assign w_store_done  = !flush && (r_state == S_STORE) && mem_ready;
    assign w_retire_fire = w_reg_retire || w_store_done;

    rob_ptr_ctrl u_ptr (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .alloc_fire  (w_alloc_fire),
        .retire_fire (w_retire_fire),
        .head        (head),
        .tail        (tail),
        .full        (full),
        .empty       (empty)
    );

    assign alloc_index = tail;
    assign rb_full     = full;
    assign rb_empty    = empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_store <= '0;
            for (int i = 0; i < RB_SIZE; i++)
                r_dest[i] <= '0;
        end else if (w_alloc_fire) begin
            r_is_store[tail] <= alloc_is_store;
            r_dest[tail]     <= alloc_dest;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_RUN;
            reg_we        <= 1'b0;
            reg_waddr     <= '0;
            reg_wdata     <= '0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            rb_free_valid <= 1'b0;
            rb_free_index <= '0;
        end else begin
            reg_we        <= w_reg_retire;
            rb_free_valid <= w_retire_fire;
            if (w_retire_fire)
                rb_free_index <= head;
            if (w_reg_retire) begin
                reg_waddr <= r_dest[head];
                reg_wdata <= slot_word(CDB_data_data, head);
            end
            // Store address/data are captured once and held until accepted.
            if (flush) begin
                mem_we  <= 1'b0;
                r_state <= S_RUN;
            end else if (w_store_start) begin
                mem_we    <= 1'b1;
                mem_addr  <= slot_word(CDB_data_addr, head);
                mem_wdata <= slot_word(CDB_data_data, head);
                r_state   <= S_STORE;
            end else if (w_store_done) begin
                mem_we  <= 1'b0;
                r_state <= S_RUN;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rob_commit_unit.sv
// ============================================================================
// tb_rob_commit_unit : directed + random scoreboard bench for rob_commit_unit
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_rob_commit_unit;
    import rob_commit_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         reset;
    logic [WORD_SIZE*RB_SIZE-1:0] cdb_data;
    logic [RB_SIZE-1:0]           cdb_valid;
    logic [WORD_SIZE*RB_SIZE-1:0] cdb_addr;
    logic                         alloc_req;
    logic                         alloc_is_store;
    logic [REG_INDEX-1:0]         alloc_dest;
    logic [RB_INDEX-1:0]          alloc_index;
    logic                         rb_full;
    logic                         rb_empty;
    logic                         reg_we;
    logic [REG_INDEX-1:0]         reg_waddr;
    logic [WORD_SIZE-1:0]         reg_wdata;
    logic                         mem_we;
    logic [WORD_SIZE-1:0]         mem_addr;
    logic [WORD_SIZE-1:0]         mem_wdata;
    logic                         mem_ready;
    logic                         rb_free_valid;
    logic [RB_INDEX-1:0]          rb_free_index;
    logic                         flush;

    rob_commit_unit dut (
        .clk            (clk),
        .reset          (reset),
        .CDB_data_data  (cdb_data),
        .CDB_data_valid (cdb_valid),
        .CDB_data_addr  (cdb_addr),
        .alloc_req      (alloc_req),
        .alloc_is_store (alloc_is_store),
        .alloc_dest     (alloc_dest),
        .alloc_index    (alloc_index),
        .rb_full        (rb_full),
        .rb_empty       (rb_empty),
        .reg_we         (reg_we),
        .reg_waddr      (reg_waddr),
        .reg_wdata      (reg_wdata),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ready      (mem_ready),
        .rb_free_valid  (rb_free_valid),
        .rb_free_index  (rb_free_index),
        .flush          (flush)
    );

    typedef struct {
        bit                   st;
        logic [REG_INDEX-1:0] dest;
        logic [WORD_SIZE-1:0] data;
        logic [WORD_SIZE-1:0] addr;
        int                   slot;
    } exp_t;

    // Expected retirements in program order.
    exp_t sb[$];

    logic [WORD_SIZE-1:0] slot_data [RB_SIZE];
    logic [WORD_SIZE-1:0] slot_addr [RB_SIZE];
    bit                   slot_busy [RB_SIZE];
    bit                   slot_done [RB_SIZE];
    int                   m_tail;
    int                   outstanding;
    int                   n_pass;
    int                   n_total;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic bad(input string name);
        n_total++;
        $display("FAIL %s: unexpected DUT event at %0t", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (reset && rb_free_valid) begin
            cdb_valid[rb_free_index] = 1'b0;
            slot_busy[rb_free_index] = 1'b0;
            slot_done[rb_free_index] = 1'b0;
            outstanding--;
        end
    endtask

    task automatic model_clear();
        sb.delete();
        m_tail      = 0;
        outstanding = 0;
        cdb_valid   = '0;
        alloc_req   = 1'b0;
        mem_ready   = 1'b0;
        flush       = 1'b0;
        for (int k = 0; k < RB_SIZE; k++) begin
            slot_busy[k] = 1'b0;
            slot_done[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        model_clear();
        reset = 1'b1;
    endtask

    task automatic alloc1(input bit st, input logic [REG_INDEX-1:0] d,
                          input logic [WORD_SIZE-1:0] data, input logic [WORD_SIZE-1:0] addr);
        exp_t e;
        check("alloc_index", 64'(alloc_index), 64'(m_tail));
        e.st = st; e.dest = d; e.data = data; e.addr = addr; e.slot = m_tail;
        sb.push_back(e);
        slot_data[m_tail] = data;
        slot_addr[m_tail] = addr;
        slot_busy[m_tail] = 1'b1;
        slot_done[m_tail] = 1'b0;
        cdb_valid[m_tail] = 1'b0;
        alloc_req      = 1'b1;
        alloc_is_store = st;
        alloc_dest     = d;
        m_tail = (m_tail + 1) % RB_SIZE;
        outstanding++;
    endtask

    task automatic alloc_step(input bit st, input logic [REG_INDEX-1:0] d,
                              input logic [WORD_SIZE-1:0] data, input logic [WORD_SIZE-1:0] addr);
        alloc1(st, d, data, addr);
        step();
        alloc_req = 1'b0;
    endtask

    task automatic complete(input int k);
        cdb_data[k*WORD_SIZE +: WORD_SIZE] = slot_data[k];
        cdb_addr[k*WORD_SIZE +: WORD_SIZE] = slot_addr[k];
        cdb_valid[k] = 1'b1;
        slot_done[k] = 1'b1;
    endtask

    task automatic drain();
        int guard;
        for (int k = 0; k < RB_SIZE; k++)
            if (slot_busy[k] && !slot_done[k]) complete(k);
        mem_ready = 1'b1;
        guard = 0;
        while (outstanding > 0 && guard < 200) begin
            step();
            guard++;
        end
        if (outstanding > 0) bad("drain_timeout");
        mem_ready = 1'b0;
        step();
        step();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        check("empty_after_drain", 64'(rb_empty), 64'd1);
    endtask

    // Monitor: compares every retirement the DUT presents against the queue head.
    initial begin
        bit                   pm;
        logic [WORD_SIZE-1:0] pa;
        logic [WORD_SIZE-1:0] pd;
        pm = 1'b0; pa = '0; pd = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pm = 1'b0;
                continue;
            end
            if (reg_we) begin
                if (mem_we) bad("reg_and_mem_together");
                if (sb.size() == 0 || sb[0].st) begin
                    bad("reg_write_unexpected");
                end else begin
                    check("reg_waddr", 64'(reg_waddr), 64'(sb[0].dest));
                    check("reg_wdata", 64'(reg_wdata), 64'(sb[0].data));
                    check("reg_free_valid", 64'(rb_free_valid), 64'd1);
                    check("reg_free_index", 64'(rb_free_index), 64'(sb[0].slot));
                    void'(sb.pop_front());
                end
            end
            if (mem_we) begin
                if (rb_free_valid) bad("free_during_store");
                if (!pm) begin
                    if (sb.size() == 0 || !sb[0].st) begin
                        bad("store_unexpected");
                    end else begin
                        check("mem_addr", 64'(mem_addr), 64'(sb[0].addr));
                        check("mem_wdata", 64'(mem_wdata), 64'(sb[0].data));
                    end
                end else begin
                    check("mem_addr_stable", 64'(mem_addr), 64'(pa));
                    check("mem_wdata_stable", 64'(mem_wdata), 64'(pd));
                end
            end else if (rb_free_valid && !reg_we) begin
                if (!pm || sb.size() == 0 || !sb[0].st) begin
                    bad("store_free_unexpected");
                end else begin
                    check("store_free_index", 64'(rb_free_index), 64'(sb[0].slot));
                    void'(sb.pop_front());
                end
            end
            pm = mem_we; pa = mem_addr; pd = mem_wdata;
        end
    end

    initial begin
        int s0;
        n_pass = 0; n_total = 0;
        cdb_data = '0; cdb_addr = '0;
        alloc_is_store = 1'b0; alloc_dest = '0;
        reset = 1'b0;
        model_clear();
        #2;
        check("rst_empty", 64'(rb_empty), 64'd1);
        check("rst_full", 64'(rb_full), 64'd0);
        check("rst_outputs", 64'({reg_we, mem_we, rb_free_valid, alloc_index, reg_waddr}), 64'd0);
        check("rst_data", 64'({reg_wdata, mem_addr}), 64'd0);
        step();
        reset = 1'b1;

        // Three register entries retire on consecutive cycles.
        alloc_step(1'b0, 5'd1, 32'hA, 32'h0);
        alloc_step(1'b0, 5'd2, 32'hB, 32'h0);
        alloc_step(1'b0, 5'd3, 32'hC, 32'h0);
        complete(0); complete(1); complete(2);
        for (int i = 0; i < 3; i++) begin
            step();
            check("seq_reg_we", 64'(reg_we), 64'd1);
            check("seq_free_index", 64'(rb_free_index), 64'(i));
        end
        check("seq_empty", 64'(rb_empty), 64'd1);
        step();
        check("seq_reg_we_idle", 64'(reg_we), 64'd0);

        // Younger slot completes first: nothing retires until the head does.
        s0 = m_tail;
        alloc_step(1'b0, 5'd5, 32'h55, 32'h0);
        alloc_step(1'b0, 5'd6, 32'h66, 32'h0);
        complete((s0 + 1) % RB_SIZE);
        step();
        check("ooo_hold0", 64'(reg_we), 64'd0);
        step();
        check("ooo_hold1", 64'(reg_we), 64'd0);
        complete(s0);
        step();
        check("ooo_first", 64'({reg_we, rb_free_index}), 64'({1'b1, 3'(s0)}));
        step();
        check("ooo_second", 64'({reg_we, rb_free_index}), 64'({1'b1, 3'(s0 + 1)}));
        step();
        check("ooo_idle", 64'({reg_we, rb_empty}), 64'b01);

        // Store held while memory stalls.
        do_reset();
        alloc_step(1'b1, 5'd0, 32'hDEAD, 32'h100);
        complete(0);
        step();
        check("st_mem_we", 64'(mem_we), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("st_hold", 64'({mem_we, rb_free_valid}), 64'b10);
            check("st_hold_addr", 64'(mem_addr), 64'h100);
            check("st_hold_data", 64'(mem_wdata), 64'hDEAD);
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("st_accept", 64'({mem_we, rb_free_valid, rb_free_index}), 64'({2'b01, 3'd0}));
        step();
        check("st_after", 64'({rb_free_valid, rb_empty}), 64'b01);

        // Fill, refused allocation, then wrap-around.
        do_reset();
        for (int i = 0; i < RB_SIZE; i++)
            alloc_step(1'b0, 5'(i + 1), $urandom, 32'h0);
        check("full_set", 64'(rb_full), 64'd1);
        alloc_req = 1'b1; alloc_dest = 5'd31; alloc_is_store = 1'b0;
        complete(0);
        step();
        alloc_req = 1'b0;
        check("full_refused_tail", 64'(alloc_index), 64'd0);
        check("full_refused_count", 64'({rb_full, reg_we, rb_free_index}), 64'({2'b01, 3'd0}));
        alloc1(1'b0, 5'd9, 32'h99, 32'h0);
        complete(1);
        step();
        alloc_req = 1'b0;
        check("wrap_tail", 64'(alloc_index), 64'd1);
        check("wrap_count", 64'({rb_full, reg_we}), 64'b01);
        alloc_step(1'b0, 5'd10, 32'h1010, 32'h0);
        check("wrap_full", 64'(rb_full), 64'd1);
        drain();

        // Flush abandons a pending store and ignores same-cycle allocation.
        do_reset();
        alloc_step(1'b1, 5'd0, 32'hBEEF, 32'h200);
        for (int i = 0; i < 4; i++)
            alloc_step(1'b0, 5'(i + 10), $urandom, 32'h0);
        complete(0);
        step();
        check("fl_store_on", 64'(mem_we), 64'd1);
        step();
        flush = 1'b1; alloc_req = 1'b1;
        step();
        model_clear();
        check("fl_outputs", 64'({mem_we, reg_we, rb_free_valid}), 64'd0);
        check("fl_empty", 64'({rb_empty, alloc_index}), 64'({1'b1, 3'd0}));
        step();
        check("fl_quiet", 64'({rb_free_valid, mem_we, rb_empty}), 64'b001);

        // Asynchronous reset in the middle of a commit.
        alloc_step(1'b0, 5'd7, 32'h77, 32'h0);
        alloc_step(1'b0, 5'd8, 32'h88, 32'h0);
        alloc_step(1'b0, 5'd9, 32'h99, 32'h0);
        complete(0); complete(1); complete(2);
        step();
        check("ar_commit", 64'(reg_we), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_outputs", 64'({reg_we, rb_free_valid, mem_we, reg_wdata}), 64'd0);
        check("ar_empty", 64'({rb_empty, alloc_index}), 64'({1'b1, 3'd0}));
        step();
        model_clear();
        reset = 1'b1;

        // Random traffic: mixed stores/registers, out-of-order completion, memory stalls.
        for (int cyc = 0; cyc < 800; cyc++) begin
            int just;
            just = -1;
            if (outstanding < RB_SIZE && $urandom_range(0, 99) < 55) begin
                just = m_tail;
                alloc1(($urandom_range(0, 3) == 0), 5'($urandom), $urandom, $urandom);
            end
            for (int j = 0; j < 2; j++) begin
                int k;
                k = $urandom_range(0, RB_SIZE - 1);
                if (k != just && slot_busy[k] && !slot_done[k] && $urandom_range(0, 99) < 60)
                    complete(k);
            end
            mem_ready = ($urandom_range(0, 99) < 50);
            step();
            alloc_req = 1'b0;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
